// File: rtl/ux607_mrom_rdr_pkg.sv
// Shared definitions for the MROM reader: FSM state encoding and word-size helpers.
package ux607_mrom_rdr_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] CMD   = 2'd1;
    localparam logic [1:0] RSP   = 2'd2;
    localparam logic [1:0] DRAIN = 2'd3;

    typedef enum logic [1:0] {
        ST_IDLE  = IDLE,
        ST_CMD   = CMD,
        ST_RSP   = RSP,
        ST_DRAIN = DRAIN
    } rdr_state_e;

    localparam int RDR_DW_DEFAULT = 32;
    localparam int RDR_BYTE_SHIFT = $clog2(RDR_DW_DEFAULT / 8);

    // log2 of bytes per word for an arbitrary data width
    function automatic int rdr_byte_shift(input int dw);
        return $clog2(dw / 8);
    endfunction

endpackage

// File: rtl/ux607_mrom_rdr_obuf.sv
// Single-entry valid/ready output buffer carrying {last, data} for the MROM reader.
module ux607_mrom_rdr_obuf
    import ux607_mrom_rdr_pkg::*;
#(
    parameter int DW = RDR_DW_DEFAULT
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          load,
    input  logic          load_last,
    input  logic [DW-1:0] load_data,
    input  logic          out_ready,
    output logic          out_valid,
    output logic [DW-1:0] out_data,
    output logic          out_last,
    output logic          pop,
    output logic          empty
);

    logic          vld_reg;
    logic          last_reg;
    logic [DW-1:0] data_reg;

    assign out_valid = vld_reg;
    assign out_data  = data_reg;
    assign out_last  = last_reg;
    assign pop       = vld_reg && out_ready;
    assign empty     = !vld_reg;

    // Loads only occur while empty, so load and pop never collide.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld_reg  <= 1'b0;
            last_reg <= 1'b0;
            data_reg <= '0;
        end else if (load) begin
            vld_reg  <= 1'b1;
            last_reg <= load_last;
            data_reg <= load_data;
        end else if (pop) begin
            vld_reg  <= 1'b0;
            last_reg <= 1'b0;
        end
    end

endmodule

// File: rtl/ux607_mrom_reader.sv
// ICB read initiator streaming a contiguous MROM word range to a valid/ready output.
// Optional XOR checksum output enabled by defining UX607_MROM_RDR_CSUM_EN.
module ux607_mrom_reader
    import ux607_mrom_rdr_pkg::*;
#(
    parameter int AW = 12,
    parameter int DW = 32,
    parameter int LW = 10
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          start,
    input  logic [AW-1:0] start_addr,
    input  logic [LW-1:0] word_cnt,
    output logic          busy,
    output logic          done,
    output logic          err,
    output logic          icb_cmd_valid,
    input  logic          icb_cmd_ready,
    output logic [AW-1:0] icb_cmd_addr,
    output logic          icb_cmd_read,
    input  logic          icb_rsp_valid,
    output logic          icb_rsp_ready,
    input  logic          icb_rsp_err,
    input  logic [DW-1:0] icb_rsp_rdata,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
`ifdef UX607_MROM_RDR_CSUM_EN
    output logic [DW-1:0] csum,
`endif
    output logic          out_last
);

    localparam int            BSH       = rdr_byte_shift(DW);
    localparam logic [AW-1:0] ADDR_STEP = AW'(1 << BSH);
    localparam logic [AW-1:0] ADDR_MASK = ~(ADDR_STEP - AW'(1));

    rdr_state_e    state_reg;
    logic [AW-1:0] cur_addr_reg;
    logic [LW-1:0] remain_reg;
    logic          done_reg;
    logic          err_reg;

    logic          obuf_empty;
    logic          obuf_pop;
    logic          cmd_hs;
    logic          rsp_hs;
    logic          capture;
    logic          last_word;

    assign busy          = (state_reg != ST_IDLE);
    assign done          = done_reg;
    assign err           = err_reg;
    assign icb_cmd_valid = (state_reg == ST_CMD);
    assign icb_cmd_addr  = cur_addr_reg;
    assign icb_cmd_read  = 1'b1;

    // Ready depends only on registered state, never on out_ready or rsp_valid.
    assign icb_rsp_ready = ((state_reg == ST_CMD) || (state_reg == ST_RSP)) && obuf_empty;

    assign cmd_hs    = icb_cmd_valid && icb_cmd_ready;
    assign rsp_hs    = icb_rsp_valid && icb_rsp_ready;
    assign capture   = ((state_reg == ST_CMD) && cmd_hs && rsp_hs) ||
                       ((state_reg == ST_RSP) && rsp_hs);
    assign last_word = (remain_reg == LW'(1));

`ifdef UX607_MROM_RDR_CSUM_EN
    logic [DW-1:0] csum_reg;
    assign csum = csum_reg;
`endif

    ux607_mrom_rdr_obuf #(.DW(DW)) u_obuf (
        .clk       (clk),
        .rst_n     (rst_n),
        .load      (capture),
        .load_last (last_word),
        .load_data (icb_rsp_rdata),
        .out_ready (out_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_last  (out_last),
        .pop       (obuf_pop),
        .empty     (obuf_empty)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg    <= ST_IDLE;
            cur_addr_reg <= '0;
            remain_reg   <= '0;
            done_reg     <= 1'b0;
            err_reg      <= 1'b0;
`ifdef UX607_MROM_RDR_CSUM_EN
            csum_reg     <= '0;
`endif
        end else begin
            done_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (start) begin
                        err_reg <= 1'b0;
`ifdef UX607_MROM_RDR_CSUM_EN
                        csum_reg <= '0;
`endif
                        if (word_cnt != '0) begin
                            state_reg    <= ST_CMD;
                            cur_addr_reg <= start_addr & ADDR_MASK;
                            remain_reg   <= word_cnt;
                        end else begin
                            state_reg <= ST_DRAIN;
                        end
                    end
                end
                ST_CMD: begin
                    if (capture) begin
                        state_reg <= last_word ? ST_DRAIN : ST_CMD;
                    end else if (cmd_hs) begin
                        state_reg <= ST_RSP;
                    end
                end
                ST_RSP: begin
                    if (capture) begin
                        state_reg <= last_word ? ST_DRAIN : ST_CMD;
                    end
                end
                ST_DRAIN: begin
                    if (obuf_empty || obuf_pop) begin
                        state_reg <= ST_IDLE;
                        done_reg  <= 1'b1;
                    end
                end
                default: state_reg <= ST_IDLE;
            endcase

            // Error words are still forwarded; the error is only remembered.
            if (capture) begin
                err_reg      <= err_reg | icb_rsp_err;
                cur_addr_reg <= cur_addr_reg + ADDR_STEP;
                remain_reg   <= remain_reg - LW'(1);
`ifdef UX607_MROM_RDR_CSUM_EN
                csum_reg     <= csum_reg ^ icb_rsp_rdata;
`endif
            end
        end
    end

endmodule

// File: tb/tb_ux607_mrom_reader.sv
// Directed self-checking bench for ux607_mrom_reader with a latency-programmable ICB responder.
module tb_ux607_mrom_reader;

    localparam int AW = 12;
    localparam int DW = 32;
    localparam int LW = 10;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          start = 1'b0;
    logic [AW-1:0] start_addr = '0;
    logic [LW-1:0] word_cnt = '0;
    logic          busy, done, err;
    logic          icb_cmd_valid, icb_cmd_ready, icb_cmd_read;
    logic [AW-1:0] icb_cmd_addr;
    logic          icb_rsp_valid, icb_rsp_ready, icb_rsp_err;
    logic [DW-1:0] icb_rsp_rdata;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [DW-1:0] out_data;
    logic          out_last;
`ifdef UX607_MROM_RDR_CSUM_EN
    logic [DW-1:0] csum;
`endif

    ux607_mrom_reader #(.AW(AW), .DW(DW), .LW(LW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .start_addr    (start_addr),
        .word_cnt      (word_cnt),
        .busy          (busy),
        .done          (done),
        .err           (err),
        .icb_cmd_valid (icb_cmd_valid),
        .icb_cmd_ready (icb_cmd_ready),
        .icb_cmd_addr  (icb_cmd_addr),
        .icb_cmd_read  (icb_cmd_read),
        .icb_rsp_valid (icb_rsp_valid),
        .icb_rsp_ready (icb_rsp_ready),
        .icb_rsp_err   (icb_rsp_err),
        .icb_rsp_rdata (icb_rsp_rdata),
        .out_valid     (out_valid),
        .out_ready     (out_ready),
        .out_data      (out_data),
`ifdef UX607_MROM_RDR_CSUM_EN
        .csum          (csum),
`endif
        .out_last      (out_last)
    );

    always #5 clk = ~clk;

    int tests = 0;
    int fails = 0;

    // Responder: one outstanding read, data = address, optional error on one address.
    int            lat = 0;
    logic          err_on = 1'b0;
    logic [AW-1:0] err_addr = '0;
    logic          pend = 1'b0;
    int            wcnt = 0;
    logic [AW-1:0] paddr = '0;
    logic [AW-1:0] raddr;

    assign icb_cmd_ready = !pend;
    assign icb_rsp_valid = pend ? (wcnt >= lat) : ((lat == 0) && icb_cmd_valid);
    assign raddr         = pend ? paddr : icb_cmd_addr;
    assign icb_rsp_rdata = DW'(raddr);
    assign icb_rsp_err   = err_on && (raddr == err_addr);

    always @(posedge clk) begin
        if (!rst_n) begin
            pend <= 1'b0;
            wcnt <= 0;
        end else if (!pend && icb_cmd_valid) begin
            if (!(icb_rsp_valid && icb_rsp_ready)) begin
                pend  <= 1'b1;
                paddr <= icb_cmd_addr;
                wcnt  <= 1;
            end
        end else if (pend) begin
            if (icb_rsp_valid && icb_rsp_ready) pend <= 1'b0;
            else wcnt <= wcnt + 1;
        end
    end

    // Monitor: monotonic counters and logs; the stimulus works with differences.
    int            cyc = 0;
    int            done_cnt = 0;
    int            done_cyc = 0;
    int            busy_cycles = 0;
    int            cmdv_cycles = 0;
    int            stall_bad = 0;
    int            stall_full = 0;
    logic [DW-1:0] rx_data[$];
    logic          rx_last[$];
    logic [AW-1:0] cmd_q[$];

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (out_valid && out_ready) begin
            rx_data.push_back(out_data);
            rx_last.push_back(out_last);
        end
        if (icb_cmd_valid && icb_cmd_ready) cmd_q.push_back(icb_cmd_addr);
        if (icb_cmd_valid) cmdv_cycles <= cmdv_cycles + 1;
        if (busy) busy_cycles <= busy_cycles + 1;
        if (done) begin
            done_cnt <= done_cnt + 1;
            done_cyc <= cyc;
        end
        if (out_valid && !out_ready && icb_rsp_ready) stall_bad <= stall_bad + 1;
        if (out_valid && !out_ready) stall_full <= stall_full + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset(input string pfx);
        check({pfx, "_busy"},      32'(busy), 0);
        check({pfx, "_done"},      32'(done), 0);
        check({pfx, "_err"},       32'(err), 0);
        check({pfx, "_cmd_valid"}, 32'(icb_cmd_valid), 0);
        check({pfx, "_rsp_ready"}, 32'(icb_rsp_ready), 0);
        check({pfx, "_out_valid"}, 32'(out_valid), 0);
        check({pfx, "_out_last"},  32'(out_last), 0);
        check({pfx, "_cmd_addr"},  32'(icb_cmd_addr), 0);
        check({pfx, "_out_data"},  out_data, 0);
`ifdef UX607_MROM_RDR_CSUM_EN
        check({pfx, "_csum"},      csum, 0);
`endif
    endtask

    task automatic launch(input logic [AW-1:0] a, input int n, output int t0);
        @(negedge clk);
        start_addr = a;
        word_cnt   = LW'(n);
        start      = 1'b1;
        t0         = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int base, input int budget);
        int k = 0;
        while (done_cnt == base && k < budget) begin
            @(negedge clk);
            k++;
        end
        check(tag, 32'(done_cnt - base), 1);
    endtask

    task automatic check_words(input string tag, input int base, input logic [AW-1:0] a0, input int n);
        logic [AW-1:0] a;
        check({tag, "_count"}, 32'(rx_data.size() - base), 32'(n));
        a = a0;
        for (int i = 0; i < n; i++) begin
            if (base + i < rx_data.size()) begin
                check({tag, "_data"}, rx_data[base + i], DW'(a));
                check({tag, "_last"}, 32'(rx_last[base + i]), (i == n - 1) ? 1 : 0);
            end
            a = a + AW'(4);
        end
    endtask

    int t0, rx0, d0, c0, b0, v0, s0, f0, k;

    initial begin
        // Reset state
        repeat (3) @(negedge clk);
        check_reset("rst");
        check("cmd_read", 32'(icb_cmd_read), 1);
        rst_n = 1'b1;

        // Zero-latency, four words from 0x100
        lat = 0;
        rx0 = rx_data.size(); d0 = done_cnt;
        launch(12'h100, 4, t0);
        wait_done("a_done", d0, 40);
        check_words("a", rx0, 12'h100, 4);
        check("a_done_time", 32'(done_cyc - t0), 9);
        check("a_err", 32'(err), 0);
`ifdef UX607_MROM_RDR_CSUM_EN
        check("a_csum", csum, 32'h0);
`endif
        $display("[TB] xfer addr=0x100 n=4 words=%0d err=%0b", rx_data.size() - rx0, err);

        // Empty transfer
        rx0 = rx_data.size(); d0 = done_cnt; v0 = cmdv_cycles; b0 = busy_cycles;
        launch(12'h123, 0, t0);
        wait_done("z_done", d0, 20);
        check("z_cmd_valid_cycles", 32'(cmdv_cycles - v0), 0);
        check("z_done_time", 32'(done_cyc - t0), 2);
        check("z_busy_cycles", 32'(busy_cycles - b0), 1);
        check("z_count", 32'(rx_data.size() - rx0), 0);
        $display("[TB] xfer addr=0x123 n=0 words=%0d err=%0b", rx_data.size() - rx0, err);

        // Latency 3, error on the second of three words
        lat = 3; err_on = 1'b1; err_addr = 12'h044;
        rx0 = rx_data.size(); d0 = done_cnt;
        launch(12'h040, 3, t0);
        wait_done("e_done", d0, 80);
        check_words("e", rx0, 12'h040, 3);
        check("e_err_sticky", 32'(err), 1);
        err_on = 1'b0;
        $display("[TB] xfer addr=0x040 n=3 words=%0d err=%0b", rx_data.size() - rx0, err);

        // Output stall after the first word; err cleared by this start
        lat = 0;
        rx0 = rx_data.size(); d0 = done_cnt;
        launch(12'h200, 4, t0);
        check("s_err_cleared", 32'(err), 0);
        k = 0;
        while (rx_data.size() == rx0 && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("s_first_word", 32'(rx_data.size() - rx0), 1);
        s0 = stall_bad; f0 = stall_full;
        out_ready = 1'b0;
        repeat (10) @(negedge clk);
        out_ready = 1'b1;
        check("s_rsp_ready_stall", 32'(stall_bad - s0), 0);
        check("s_stall_seen", 32'((stall_full - f0) >= 8), 1);
        wait_done("s_done", d0, 60);
        check_words("s", rx0, 12'h200, 4);
        $display("[TB] xfer addr=0x200 n=4 words=%0d err=%0b", rx_data.size() - rx0, err);

        // Address wrap at the top of a 12-bit space
        rx0 = rx_data.size(); d0 = done_cnt; c0 = cmd_q.size();
        launch(12'hFF8, 3, t0);
        wait_done("w_done", d0, 40);
        check("w_cmd_count", 32'(cmd_q.size() - c0), 3);
        if (cmd_q.size() - c0 >= 3) begin
            check("w_addr0", 32'(cmd_q[c0]), 32'hFF8);
            check("w_addr1", 32'(cmd_q[c0 + 1]), 32'hFFC);
            check("w_addr2", 32'(cmd_q[c0 + 2]), 32'h000);
        end
        check_words("w", rx0, 12'hFF8, 3);
`ifdef UX607_MROM_RDR_CSUM_EN
        check("w_csum", csum, 32'h004);
`endif
        $display("[TB] xfer addr=0xff8 n=3 words=%0d err=%0b", rx_data.size() - rx0, err);

        // Reset mid-transfer with a start pulse while busy
        lat = 2;
        rx0 = rx_data.size(); d0 = done_cnt; c0 = cmd_q.size();
        launch(12'h300, 8, t0);
        repeat (5) @(negedge clk);
        start_addr = 12'h800; word_cnt = LW'(5); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check_reset("mid");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("mid_idle_after", 32'(busy), 0);
        check("mid_no_done", 32'(done_cnt - d0), 0);
        check("mid_cmds_seen", 32'((cmd_q.size() - c0) >= 2), 1);
        for (int i = c0; i < cmd_q.size(); i++) begin
            check("mid_cmd_addr", 32'(cmd_q[i]), 32'h300 + 32'(4 * (i - c0)));
        end
        $display("[TB] xfer addr=0x300 n=8 aborted words=%0d", rx_data.size() - rx0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
